// File: rtl/sm_sdram_arbiter.sv
// rtl/sm_sdram_arbiter.sv - two-port req/ack arbiter in front of sm_sdram_controller
//
// Purpose: serialises word accesses from two independent requesters onto a
// single sm_sdram_controller command port (sd_clk0 domain) and returns read
// data to whichever port owned the access.
//
// Ports:
//   clkIn, rst_n              clock (rising edge), async active-low reset
//   pN_req/we/a/wd            port N request, direction, address, write data
//   pN_ack                    one-cycle completion pulse for port N
//   pN_rd                     port N read data, updated only by its own read acks
//   mc_ready, mc_rd           controller idle flag and read data
//   mc_cs/we/a/wd             controller command strobe and command fields
//   gnt                       one-hot current owner, 00 when idle
//
// Build option: define SM_SDRAM_ARB_PRIO_EN for fixed priority (port 0 wins
// ties, no last-served pointer); default build is round robin.
module sm_sdram_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int START_TO = 4
) (
  input  logic          clkIn,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_a,
  input  logic [DW-1:0] p0_wd,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rd,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_a,
  input  logic [DW-1:0] p1_wd,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rd,
  input  logic          mc_ready,
  input  logic [DW-1:0] mc_rd,
  output logic          mc_cs,
  output logic          mc_we,
  output logic [AW-1:0] mc_a,
  output logic [DW-1:0] mc_wd,
  output logic [1:0]    gnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    to_cnt_q;
  logic          mc_cs_q;
  logic          mc_we_q;
  logic [AW-1:0] mc_a_q;
  logic [DW-1:0] mc_wd_q;
  logic [1:0]    gnt_q;
  logic          p0_ack_q;
  logic          p1_ack_q;
  logic [DW-1:0] p0_rd_q;
  logic [DW-1:0] p1_rd_q;
`ifndef SM_SDRAM_ARB_PRIO_EN
  logic          last_q;  // 1: port 1 was served last
`endif

  logic pick1;   // winner of the current IDLE decision is port 1
  logic finish;  // access complete this cycle; move to DONE on the next edge

  always_comb begin
`ifdef SM_SDRAM_ARB_PRIO_EN
    pick1 = !p0_req;
`else
    // Port 1 wins alone, or in a tie when port 0 was the last one served.
    pick1 = p1_req && (!p0_req || !last_q);
`endif
    // A controller that never drops ready is assumed to have finished the
    // command on its own once the timeout expires.
    finish = ((state_q == S_WAIT_BUSY) && mc_ready && (to_cnt_q == 4'(START_TO - 1))) ||
             ((state_q == S_WAIT_DONE) && mc_ready);
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      mc_cs_q  <= 1'b0;
      mc_we_q  <= 1'b0;
      mc_a_q   <= '0;
      mc_wd_q  <= '0;
      gnt_q    <= 2'b00;
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p0_rd_q  <= '0;
      p1_rd_q  <= '0;
`ifndef SM_SDRAM_ARB_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mc_ready && (p0_req || p1_req)) begin
            gnt_q   <= pick1 ? 2'b10 : 2'b01;
            mc_we_q <= pick1 ? p1_we : p0_we;
            mc_a_q  <= pick1 ? p1_a : p0_a;
            mc_wd_q <= pick1 ? p1_wd : p0_wd;
            mc_cs_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mc_cs_q  <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!mc_ready)
            state_q <= S_WAIT_DONE;
          else if (!finish)
            to_cnt_q <= to_cnt_q + 4'd1;
        end
        S_WAIT_DONE: ;
        S_DONE: begin
          gnt_q   <= 2'b00;
`ifndef SM_SDRAM_ARB_PRIO_EN
          last_q  <= gnt_q[1];
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Ack is registered so it is high during DONE; read data is captured
      // on the same edge while mc_rd is valid.
      if (finish) begin
        state_q  <= S_DONE;
        p0_ack_q <= gnt_q[0];
        p1_ack_q <= gnt_q[1];
        if (!mc_we_q) begin
          if (gnt_q[0]) p0_rd_q <= mc_rd;
          if (gnt_q[1]) p1_rd_q <= mc_rd;
        end
      end
    end
  end

  assign mc_cs  = mc_cs_q;
  assign mc_we  = mc_we_q;
  assign mc_a   = mc_a_q;
  assign mc_wd  = mc_wd_q;
  assign gnt    = gnt_q;
  assign p0_ack = p0_ack_q;
  assign p1_ack = p1_ack_q;
  assign p0_rd  = p0_rd_q;
  assign p1_rd  = p1_rd_q;

endmodule
